// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: op codes, FSM states
// and the decode-side funct values that map onto them.
package ex_muldiv_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;

    // True for the ops that occupy the unit for multiple cycles.
    function automatic logic md_is_arith(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/ex_md_arith.sv
// Combinational product/quotient/remainder for the latched mult/div operands,
// including the divide-by-zero and min_int/-1 results.
module ex_md_arith
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  md_op_e             i_op,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [WIDTH-1:0]   o_hi,
    output logic [WIDTH-1:0]   o_lo
);

    localparam int unsigned W2 = 2 * WIDTH;
    localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONE = {WIDTH{1'b1}};

    logic [W2-1:0]    w_prod_s;
    logic [W2-1:0]    w_prod_u;
    logic             w_a_neg;
    logic             w_b_neg;
    logic             w_signed;
    logic [WIDTH-1:0] w_num;
    logic [WIDTH-1:0] w_den;
    logic [WIDTH-1:0] w_den_safe;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_r;
    logic [WIDTH-1:0] w_q_s;
    logic [WIDTH-1:0] w_r_s;
    logic             w_div_zero;
    logic             w_div_ovf;

    assign w_prod_s = {{WIDTH{i_a[WIDTH-1]}}, i_a} * {{WIDTH{i_b[WIDTH-1]}}, i_b};
    assign w_prod_u = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

    // One unsigned divider shared by DIV (on magnitudes) and DIVU.
    assign w_signed   = (i_op == MD_DIV);
    assign w_a_neg    = w_signed & i_a[WIDTH-1];
    assign w_b_neg    = w_signed & i_b[WIDTH-1];
    assign w_num      = w_a_neg ? (~i_a + WIDTH'(1)) : i_a;
    assign w_den      = w_b_neg ? (~i_b + WIDTH'(1)) : i_b;
    assign w_den_safe = (w_den == '0) ? WIDTH'(1) : w_den;
    assign w_q        = w_num / w_den_safe;
    assign w_r        = w_num % w_den_safe;
    assign w_q_s      = (w_a_neg ^ w_b_neg) ? (~w_q + WIDTH'(1)) : w_q;
    assign w_r_s      = w_a_neg ? (~w_r + WIDTH'(1)) : w_r;
    assign w_div_zero = (i_b == '0);
    assign w_div_ovf  = (i_a == MIN_INT) && (i_b == ALL_ONE);

    always_comb begin
        o_hi = '0;
        o_lo = '0;
        case (i_op)
            MD_MULT:  {o_hi, o_lo} = w_prod_s;
            MD_MULTU: {o_hi, o_lo} = w_prod_u;
            MD_DIV: begin
                if (w_div_zero) begin
                    o_hi = i_a;
                    o_lo = ALL_ONE;
                end else if (w_div_ovf) begin
                    o_hi = '0;
                    o_lo = MIN_INT;
                end else begin
                    o_hi = w_r_s;
                    o_lo = w_q_s;
                end
            end
            MD_DIVU: begin
                if (w_div_zero) begin
                    o_hi = i_a;
                    o_lo = ALL_ONE;
                end else begin
                    o_hi = w_r;
                    o_lo = w_q;
                end
            end
            default: begin
                o_hi = '0;
                o_lo = '0;
            end
        endcase
    end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage multi-cycle multiply/divide unit owning the architectural HI/LO
// registers; busy stalls dependent instructions while an op is in flight.
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam logic [CNT_W-1:0] MULT_LAST = CNT_W'(MULT_CYCLES - 1);
    localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(DIV_CYCLES - 1);

    md_state_e        r_state;
    md_state_e        w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    md_op_e           r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic [WIDTH-1:0] w_hi_nxt;
    logic [WIDTH-1:0] w_lo_nxt;
    logic             w_issue;
    logic             w_issue_arith;
    logic             w_is_div;
    logic [WIDTH-1:0] w_res_hi;
    logic [WIDTH-1:0] w_res_lo;

    assign w_issue       = start & ~flush & (r_state == ST_IDLE);
    assign w_issue_arith = w_issue & md_is_arith(op);
    assign w_is_div      = (op == MD_DIV) || (op == MD_DIVU);

    ex_md_arith #(
        .WIDTH (WIDTH)
    ) u_arith (
        .i_op (r_op),
        .i_a  (r_a),
        .i_b  (r_b),
        .o_hi (w_res_hi),
        .o_lo (w_res_lo)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_issue_arith) w_state_nxt = ST_RUN;
            ST_RUN:  if (flush || (r_cnt == '0)) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Flush always beats completion, so a flushed op never writes HI/LO.
    always_comb begin
        w_cnt_nxt  = r_cnt;
        w_busy_nxt = r_busy;
        w_done_nxt = 1'b0;
        w_hi_nxt   = r_hi;
        w_lo_nxt   = r_lo;
        case (r_state)
            ST_IDLE: begin
                if (w_issue_arith) begin
                    w_cnt_nxt  = w_is_div ? DIV_LAST : MULT_LAST;
                    w_busy_nxt = 1'b1;
                end else if (w_issue && (op == MD_MTHI)) begin
                    w_hi_nxt = a;
                end else if (w_issue && (op == MD_MTLO)) begin
                    w_lo_nxt = a;
                end
            end
            ST_RUN: begin
                if (flush) begin
                    w_cnt_nxt  = '0;
                    w_busy_nxt = 1'b0;
                end else if (r_cnt == '0) begin
                    w_busy_nxt = 1'b0;
                    w_done_nxt = 1'b1;
                    w_hi_nxt   = w_res_hi;
                    w_lo_nxt   = w_res_lo;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_cnt_nxt  = '0;
                w_busy_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else begin
            r_cnt  <= w_cnt_nxt;
            r_busy <= w_busy_nxt;
            r_done <= w_done_nxt;
            r_hi   <= w_hi_nxt;
            r_lo   <= w_lo_nxt;
        end
    end

    // Operands are captured only at issue; a/b are free to change during RUN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op <= MD_MULT;
            r_a  <= '0;
            r_b  <= '0;
        end else if (w_issue_arith) begin
            r_op <= md_op_e'(op);
            r_a  <= a;
            r_b  <= b;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
